// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM plus MMIO console FIFO, status, cycle counter and TOHOST
module dmem_responder #(
    parameter int          ADDR_WIDTH    = 16,
    parameter logic [31:0] MMIO_BASE     = 32'hFFFF0000,
    parameter int          CONSOLE_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] dataAddress,
    input  logic [31:0] data_o,
    input  logic [3:0]  MemWrite,
    output logic [31:0] data_i,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        halt,
    output logic [31:0] exit_code
);
    localparam int LW    = $clog2(CONSOLE_DEPTH);
    localparam int WORDS = 2 ** (ADDR_WIDTH - 2);
    logic [31:0]           mem [WORDS];
    logic [7:0]            fifo [CONSOLE_DEPTH];
    logic [LW-1:0]         wr_ptr, rd_ptr;
    logic [LW:0]           count;
    logic [31:0]           cycle;
    logic                  overflow;
    logic                  in_mmio, any_we, full, pop, push_req, push, ovf_set, clr_ovf, tohost_wr;
    logic [1:0]            offset;
    logic [ADDR_WIDTH-3:0] word;
    logic [31:0]           mmio_rd;
    logic                  unused_addr;
    // address decode, FIFO handshakes and MMIO read mux
    always_comb begin
        in_mmio     = dataAddress[31:16] == MMIO_BASE[31:16];
        offset      = dataAddress[3:2];
        word        = dataAddress[ADDR_WIDTH-1:2];
        unused_addr = ^dataAddress[1:0];
        any_we      = |MemWrite;
        full        = count[LW];
        tx_valid    = count != '0;
        tx_data     = tx_valid ? fifo[rd_ptr] : 8'h00;
        pop         = tx_valid && tx_ready;
        push_req    = in_mmio && offset == 2'd0 && MemWrite[0];
        push        = push_req && (!full || pop);
        ovf_set     = push_req && full && !pop;
        clr_ovf     = in_mmio && offset == 2'd1 && any_we;
        tohost_wr   = in_mmio && offset == 2'd3 && any_we && data_o != '0 && !halt;
        mmio_rd     = offset == 2'd0 ? 32'h0 :
                      offset == 2'd1 ? {30'b0, overflow, full} :
                      offset == 2'd2 ? cycle : exit_code;
    end
    // RAM byte-lane writes and FIFO storage; neither is reset
    always_ff @(posedge clock) begin
        for (int n = 0; n < 4; n++)
            if (!in_mmio && MemWrite[n]) mem[word][8*n +: 8] <= data_o[8*n +: 8];
        if (push) fifo[wr_ptr] <= data_o[7:0];
    end
    // registered read data, FIFO pointers, counters and halt state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            data_i    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            cycle     <= '0;
            overflow  <= 1'b0;
            halt      <= 1'b0;
            exit_code <= '0;
        end else begin
            data_i   <= in_mmio ? mmio_rd : mem[word];
            wr_ptr   <= wr_ptr + LW'(push);
            rd_ptr   <= rd_ptr + LW'(pop);
            count    <= count + (LW+1)'(push) - (LW+1)'(pop);
            cycle    <= halt ? cycle : cycle + 32'd1;
            overflow <= ovf_set ? 1'b1 : clr_ovf ? 1'b0 : overflow;
            if (tohost_wr) begin
                halt      <= 1'b1;
                exit_code <= data_o;
            end
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: vector table plus scoreboarded multi-cycle sequences for dmem_responder
module tb_dmem_responder;
    logic        clock = 1'b0, clk_en = 1'b1, reset = 1'b0;
    logic [31:0] dataAddress = '0, data_o = '0;
    logic [3:0]  MemWrite = '0;
    logic        tx_ready = 1'b0;
    logic [31:0] data_i, exit_code;
    logic [7:0]  tx_data;
    logic        tx_valid, halt;
    int          checks = 0, errors = 0;
    logic [31:0] m_cycle = '0;
    logic        m_halt = 1'b0;

    typedef struct { logic [31:0] addr; logic [31:0] wd; logic [3:0] we; logic chk; logic [31:0] exp; } vec_t;
    typedef struct { logic c; logic [31:0] e; } sb_t;
    sb_t   sb[$];
    string sb_name[$];
    vec_t  vt[13];

    dmem_responder dut (
        .clock(clock), .reset(reset), .dataAddress(dataAddress), .data_o(data_o),
        .MemWrite(MemWrite), .data_i(data_i), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .halt(halt), .exit_code(exit_code)
    );

    always #5 clock = clk_en ? ~clock : clock;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] w,
                       input logic rdy, input logic c, input logic [31:0] e, input string nm);
        sb_t   s;
        string n;
        logic  th;
        dataAddress = a; data_o = wd; MemWrite = w; tx_ready = rdy;
        sb.push_back('{c, e});
        sb_name.push_back(nm);
        th = a[31:16] == 16'hFFFF && a[3:2] == 2'd3 && w != 4'h0 && wd != 0 && !m_halt;
        @(posedge clock);
        #1;
        if (!m_halt) m_cycle = m_cycle + 1;
        if (th) m_halt = 1'b1;
        s = sb.pop_front();
        n = sb_name.pop_front();
        if (s.c) check(n, data_i, s.e);
    endtask

    task automatic idle(input logic rdy);
        cyc(32'h100, 0, 4'h0, rdy, 1'b0, 0, "idle");
    endtask

    initial begin
        vt[0]  = '{32'h0000_0100, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0};
        vt[1]  = '{32'h0000_0100, 32'h0000AA00, 4'h2, 1'b1, 32'hDEADBEEF};
        vt[2]  = '{32'h0000_0100, 32'h0,        4'h0, 1'b1, 32'hDEADAAEF};
        vt[3]  = '{32'h0000_0100, 32'h55000066, 4'h9, 1'b1, 32'hDEADAAEF};
        vt[4]  = '{32'h0000_0100, 32'h0,        4'h0, 1'b1, 32'h55ADAA66};
        vt[5]  = '{32'h0000_0200, 32'h12345678, 4'hF, 1'b0, 32'h0};
        vt[6]  = '{32'h0001_0202, 32'h0,        4'h0, 1'b1, 32'h12345678};
        vt[7]  = '{32'h0000_0008, 32'h11112222, 4'hF, 1'b0, 32'h0};
        vt[8]  = '{32'hFFFF_0008, 32'hCAFEF00D, 4'hF, 1'b0, 32'h0};
        vt[9]  = '{32'h0000_0008, 32'h0,        4'h0, 1'b1, 32'h11112222};
        vt[10] = '{32'hFFFF_0000, 32'h0,        4'h0, 1'b1, 32'h0};
        vt[11] = '{32'hFFFF_0004, 32'h0,        4'h0, 1'b1, 32'h0};
        vt[12] = '{32'hFFFF_003C, 32'h0,        4'h0, 1'b1, 32'h0};

        repeat (2) @(posedge clock);
        #1;
        check("rst_data_i", data_i, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_halt", {31'b0, halt}, 0);
        check("rst_exit", exit_code, 0);
        @(negedge clock);
        reset = 1'b1;

        foreach (vt[i]) cyc(vt[i].addr, vt[i].wd, vt[i].we, 1'b0, vt[i].chk, vt[i].exp, $sformatf("vec%0d", i));

        cyc(32'hFFFF0000, 32'h48, 4'h1, 1'b0, 1'b0, 0, "push48");
        check("tx_valid_first", {31'b0, tx_valid}, 1);
        cyc(32'hFFFF0000, 32'h69, 4'h1, 1'b0, 1'b0, 0, "push69");
        check("tx_head_48", {24'b0, tx_data}, 32'h48);
        idle(1'b1);
        check("tx_head_69", {24'b0, tx_data}, 32'h69);
        idle(1'b1);
        check("tx_empty", {31'b0, tx_valid}, 0);

        for (int i = 0; i < 17; i++) cyc(32'hFFFF0000, 32'h41 + i, 4'h1, 1'b0, 1'b0, 0, "fill");
        cyc(32'hFFFF0004, 0, 4'h0, 1'b0, 1'b1, 32'h3, "status_ovf_full");
        cyc(32'hFFFF0004, 0, 4'hF, 1'b0, 1'b1, 32'h3, "status_clr_old");
        cyc(32'hFFFF0004, 0, 4'h0, 1'b0, 1'b1, 32'h1, "status_cleared");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain%0d", i), {23'b0, tx_valid, tx_data}, {23'b0, 1'b1, 8'(8'h41 + i)});
            idle(1'b1);
        end
        check("drain_empty", {31'b0, tx_valid}, 0);

        for (int i = 0; i < 16; i++) cyc(32'hFFFF0000, 32'h61 + i, 4'h1, 1'b0, 1'b0, 0, "fill2");
        cyc(32'hFFFF0000, 32'h7A, 4'h1, 1'b1, 1'b0, 0, "push_pop_full");
        cyc(32'hFFFF0004, 0, 4'h0, 1'b0, 1'b1, 32'h1, "status_no_ovf");
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain2_%0d", i), {24'b0, tx_data}, i == 15 ? 32'h7A : 32'h62 + i);
            idle(1'b1);
        end

        cyc(32'hFFFF0008, 0, 4'h0, 1'b0, 1'b1, m_cycle, "cycle_run");
        cyc(32'hFFFF000C, 0, 4'hF, 1'b0, 1'b0, 0, "tohost_zero");
        check("halt_zero_store", {31'b0, halt}, 0);
        cyc(32'hFFFF000C, 1, 4'hF, 1'b0, 1'b0, 0, "tohost_one");
        check("halt_set", {31'b0, halt}, 1);
        check("exit_one", exit_code, 1);
        cyc(32'hFFFF0008, 0, 4'h0, 1'b0, 1'b1, m_cycle, "cycle_frozen_a");
        repeat (5) idle(1'b0);
        cyc(32'hFFFF0008, 0, 4'h0, 1'b0, 1'b1, m_cycle, "cycle_frozen_b");
        cyc(32'hFFFF000C, 5, 4'hF, 1'b0, 1'b0, 0, "tohost_five");
        cyc(32'hFFFF000C, 0, 4'h0, 1'b0, 1'b1, 32'h1, "tohost_read");
        check("exit_sticky", exit_code, 1);

        for (int i = 0; i < 3; i++) cyc(32'hFFFF0000, 32'h30 + i, 4'h1, 1'b0, 1'b0, 0, "push_pre_rst");
        cyc(32'h100, 0, 4'h0, 1'b1, 1'b1, 32'h55ADAA66, "ram_after_halt");
        clk_en = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("arst_tx_valid", {31'b0, tx_valid}, 0);
        check("arst_halt", {31'b0, halt}, 0);
        check("arst_data_i", data_i, 0);
        check("arst_exit", exit_code, 0);
        #2 reset = 1'b1;
        m_cycle = '0;
        m_halt = 1'b0;
        clk_en = 1'b1;
        cyc(32'h100, 0, 4'h0, 1'b0, 1'b1, 32'h55ADAA66, "ram_retained");
        cyc(32'hFFFF0008, 0, 4'h0, 1'b0, 1'b1, m_cycle, "cycle_restart");
        check("post_rst_tx_valid", {31'b0, tx_valid}, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
